// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter that shares one single-port SRAM macro between NUM_REQ requesters,
// with registered macro pins, a 3-cycle read return and an optional zero-fill after reset.
module sram_port_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wmask,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        init_done,
  output logic                        sram_cen,
  output logic                        sram_gwen,
  output logic [DATA_W-1:0]           sram_wen,
  output logic [ADDR_W-1:0]           sram_a,
  output logic [DATA_W-1:0]           sram_d,
  input  logic [DATA_W-1:0]           sram_q
);

  localparam int   IDX_W    = $clog2(NUM_REQ);
  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  logic              state;
  logic [ADDR_W:0]   clr_cnt;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [IDX_W:0]    cand;

  logic              tag_v1, tag_v2;
  logic [IDX_W-1:0]  tag_id1, tag_id2;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] sel_wmask;
  logic              sel_we;

  assign init_done = (state == ST_RUN);

  // Search upward from ptr, wrapping; the first valid requester wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    req_ready = '0;
    if (state == ST_RUN) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = {1'b0, ptr} + (IDX_W+1)'(i);
        if (cand >= (IDX_W+1)'(NUM_REQ))
          cand = cand - (IDX_W+1)'(NUM_REQ);
        if (!gnt_any && req_valid[cand[IDX_W-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = cand[IDX_W-1:0];
        end
      end
      req_ready = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    end
  end

  assign sel_addr  = req_addr [gnt_idx*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
  assign sel_wmask = req_wmask[gnt_idx*DATA_W +: DATA_W];
  assign sel_we    = req_we[gnt_idx];

  // Control state and macro pins; strobes default to idle every cycle, a/d hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt   <= '0;
      ptr       <= '0;
      sram_cen  <= 1'b1;
      sram_gwen <= 1'b1;
      sram_wen  <= '1;
      sram_a    <= '0;
      sram_d    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sram_cen  <= 1'b1;
      sram_gwen <= 1'b1;
      sram_wen  <= '1;
      if (state == ST_CLEAR) begin
        // The extra count past the last word gives one idle cycle before RUN.
        if (!clr_cnt[ADDR_W]) begin
          sram_cen  <= 1'b0;
          sram_gwen <= 1'b0;
          sram_wen  <= '0;
          sram_a    <= clr_cnt[ADDR_W-1:0];
          sram_d    <= '0;
          clr_cnt   <= clr_cnt + (ADDR_W+1)'(1);
        end else begin
          state <= ST_RUN;
        end
      end else if (gnt_any) begin
        sram_cen <= 1'b0;
        sram_a   <= sel_addr;
        if (sel_we) begin
          sram_gwen <= 1'b0;
          sram_wen  <= ~sel_wmask;
          sram_d    <= sel_wdata;
        end
        ptr <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
      end
    end
  end

  // Requester tag follows each read: pins (t+1), macro output (t+2), response (t+3).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v1    <= 1'b0;
      tag_id1   <= '0;
      tag_v2    <= 1'b0;
      tag_id2   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      tag_v1    <= (state == ST_RUN) && gnt_any && !sel_we;
      tag_id1   <= gnt_idx;
      tag_v2    <= tag_v1;
      tag_id2   <= tag_id1;
      rsp_valid <= tag_v2 ? (NUM_REQ'(1) << tag_id2) : '0;
      if (tag_v2)
        rsp_rdata <= sram_q;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench: behavioural macro + cycle-indexed reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sram_port_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 8;
  localparam int WORDS     = 512;
  localparam int RUN_CYCLE = WORDS + 1;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req_valid, req_ready, req_we, rsp_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata, req_wmask;
  logic [DATA_W-1:0]         rsp_rdata, sram_wen, sram_d, sram_q;
  logic [ADDR_W-1:0]         sram_a;
  logic                      init_done, sram_cen, sram_gwen;

  int n_checks = 0;
  int n_errors = 0;

  sram_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Macro behaviour: starts with garbage so the zero-fill is observable.
  logic [DATA_W-1:0] macro_mem [WORDS];
  initial for (int i = 0; i < WORDS; i++) macro_mem[i] = DATA_W'($urandom);
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen)
        macro_mem[sram_a] = (macro_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else
        sram_q <= macro_mem[sram_a];
    end
  end

  // Reference model, indexed by cycle number c since reset release.
  logic [DATA_W-1:0] mmem [WORDS];
  int                rc, c, mptr, g, j;
  bit                cmd_v, cmd_we;
  int                cmd_id;
  logic [ADDR_W-1:0] cmd_a, last_a, e_a;
  logic [DATA_W-1:0] cmd_d, cmd_m, last_d, e_d, e_wen;
  logic              e_cen, e_gwen;
  logic [NUM_REQ-1:0] e_ready;
  bit                rv [4];
  int                rid [4];
  logic [DATA_W-1:0] rdat [4];

  always @(negedge clk) begin
    if (rst) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_init_done", init_done, 0);
      check("rst_cen", sram_cen, 1);
      check("rst_gwen", sram_gwen, 1);
      check("rst_wen", sram_wen, 8'hFF);
      check("rst_a", sram_a, 0);
      check("rst_d", sram_d, 0);
      rc = 0; mptr = 0; cmd_v = 0; last_a = '0; last_d = '0;
      for (int k = 0; k < 4; k++) rv[k] = 0;
    end else begin
      c = rc;
      rc++;
      check("init_done", init_done, (c >= RUN_CYCLE) ? 1 : 0);

      if (c >= 1 && c <= WORDS) begin
        e_cen = 0; e_gwen = 0; e_wen = '0; e_a = ADDR_W'(c - 1); e_d = '0;
      end else if (cmd_v) begin
        e_cen = 0; e_gwen = !cmd_we; e_a = cmd_a;
        e_wen = cmd_we ? ~cmd_m : 8'hFF;
        e_d = cmd_we ? cmd_d : last_d;
      end else begin
        e_cen = 1; e_gwen = 1; e_wen = 8'hFF; e_a = last_a; e_d = last_d;
      end
      last_a = e_a; last_d = e_d;
      check("pin_cen", sram_cen, e_cen);
      check("pin_gwen", sram_gwen, e_gwen);
      check("pin_wen", sram_wen, e_wen);
      check("pin_a", sram_a, e_a);
      check("pin_d", sram_d, e_d);

      if (c == WORDS)
        for (int k = 0; k < WORDS; k++) mmem[k] = '0;
      if (cmd_v) begin
        if (cmd_we) mmem[cmd_a] = (mmem[cmd_a] & ~cmd_m) | (cmd_d & cmd_m);
        else begin
          rv[(c + 2) % 4] = 1; rid[(c + 2) % 4] = cmd_id; rdat[(c + 2) % 4] = mmem[cmd_a];
        end
      end

      check("rsp_valid", rsp_valid, rv[c % 4] ? (1 << rid[c % 4]) : 0);
      if (rv[c % 4]) check("rsp_rdata", rsp_rdata, rdat[c % 4]);
      rv[c % 4] = 0;

      g = -1;
      if (c >= RUN_CYCLE)
        for (int i = 0; i < NUM_REQ; i++) begin
          j = (mptr + i) % NUM_REQ;
          if (g < 0 && req_valid[j]) g = j;
        end
      e_ready = (g >= 0) ? NUM_REQ'(1 << g) : '0;
      check("req_ready", req_ready, e_ready);
      cmd_v = (g >= 0);
      if (g >= 0) begin
        cmd_id = g; cmd_we = req_we[g];
        cmd_a = req_addr[g*ADDR_W +: ADDR_W];
        cmd_d = req_wdata[g*DATA_W +: DATA_W];
        cmd_m = req_wmask[g*DATA_W +: DATA_W];
        mptr = (g + 1) % NUM_REQ;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input bit we, input int addr, input int data, input int mask);
    req_we[r] = we;
    req_addr[r*ADDR_W +: ADDR_W]  = ADDR_W'(addr);
    req_wdata[r*DATA_W +: DATA_W] = DATA_W'(data);
    req_wmask[r*DATA_W +: DATA_W] = DATA_W'(mask);
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 2000) begin
      step();
      n++;
    end
    check("init_timeout", init_done, 1);
    check("init_cycles", n, RUN_CYCLE);
  endtask

  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    wait_init();

    // Fairness: continuous reads from both, grants alternate from requester 0.
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        set_req(0, 0, 'h100 + k, 0, 0);
        set_req(1, 0, 'h180 + k, 0, 0);
        req_valid = '1;
      end else req_valid = '0;
      @(negedge clk);
      if (k < 4) check("fair_ready", req_ready, (k % 2 != 0) ? 2'b10 : 2'b01);
      if (k >= 3) check("fair_rsp", rsp_valid, ((k - 3) % 2 != 0) ? 2'b10 : 2'b01);
      step();
    end

    // Write then read.
    set_req(0, 1, 'h1A5, 'h3C, 'hFF); req_valid = 2'b01; step();
    set_req(0, 0, 'h1A5, 0, 0); step();
    req_valid = '0; step();
    @(negedge clk); check("wr_rd_lat2", rsp_valid, 0);
    step();
    @(negedge clk); check("wr_rd_valid", rsp_valid, 2'b01); check("wr_rd_data", rsp_rdata, 'h3C);

    // Masked write.
    step();
    set_req(0, 1, 'h010, 'hFF, 'hFF); req_valid = 2'b01; step();
    set_req(0, 1, 'h010, 'hAB, 'h0F); step();
    req_valid = '0;
    @(negedge clk); check("mask_wen", sram_wen, 'hF0);
    step();
    set_req(0, 0, 'h010, 0, 0); req_valid = 2'b01; step();
    req_valid = '0; step(); step();
    @(negedge clk); check("mask_valid", rsp_valid, 2'b01); check("mask_data", rsp_rdata, 'hFB);

    // Same-address back-to-back across requesters.
    step();
    set_req(1, 1, 'h055, 'h77, 'hFF); req_valid = 2'b10; step();
    set_req(0, 0, 'h055, 0, 0); req_valid = 2'b01; step();
    req_valid = '0; step(); step();
    @(negedge clk); check("b2b_valid", rsp_valid, 2'b01); check("b2b_data", rsp_rdata, 'h77);

    // Randomized traffic on a small address window to provoke hazards.
    step();
    for (int k = 0; k < 400; k++) begin
      req_valid = NUM_REQ'($urandom);
      for (int r = 0; r < NUM_REQ; r++)
        set_req(r, 1'($urandom), 'h50 + int'($urandom_range(0, 15)), int'($urandom), int'($urandom));
      step();
    end
    req_valid = '0;
    repeat (4) step();

    // Reset with two reads in flight.
    set_req(0, 0, 'h055, 0, 0); set_req(1, 0, 'h010, 0, 0); req_valid = '1;
    step(); step();
    req_valid = '0; rst = 1;
    @(negedge clk); check("midop_rsp", rsp_valid, 0); check("midop_cen", sram_cen, 1);
    step(); step();
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_rsp", rsp_valid, 0);
      if (k == 1) begin
        check("restart_a", sram_a, 0);
        check("restart_gwen", sram_gwen, 0);
      end
      step();
    end

    // Reset during the clear sequence, then confirm the array is zeroed.
    repeat (100) step();
    rst = 1; step(); step(); rst = 0;
    wait_init();
    set_req(0, 0, 'h1A5, 0, 0); req_valid = 2'b01; step();
    req_valid = '0; step(); step();
    @(negedge clk); check("clr_valid", rsp_valid, 2'b01); check("clr_data", rsp_rdata, 0);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Controller that shares one `gf180mcu_fd_ip_sram__sram512x8m8wm1` macro between `NUM_REQ` requesters inside `chip_core`.
- Round-robin arbitration with a valid/ready request handshake.
- Flop-driven macro pins and pipelined read return, sustaining one access per cycle.
- Optional zero-fill of the whole array after reset, before any requester is served.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, legal range 2..4.
- `ADDR_W`, 9: word address width (512 words).
- `DATA_W`, 8: data width, equal to the write-mask width.
- `CLEAR_ON_RESET`, 1: 1 = zero-fill all words after reset; 0 = skip the fill.

Ports:
- `clk` in 1: single clock for the block and the macro.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester grant; a request is accepted in a cycle where `valid` and `ready` are both high.
- `req_we` in `NUM_REQ`: 1 = write, 0 = read.
- `req_addr` in `NUM_REQ*ADDR_W`: packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- `req_wdata` in `NUM_REQ*DATA_W`: packed write data.
- `req_wmask` in `NUM_REQ*DATA_W`: packed write byte-lane mask, active-high per bit.
- `rsp_valid` out `NUM_REQ`: one-hot read-data valid, identifying the requester.
- `rsp_rdata` out `DATA_W`: read data, shared by all requesters.
- `init_done` out 1: high once the clear sequence has finished (or immediately when `CLEAR_ON_RESET` = 0).
- `sram_cen` out 1: macro chip enable, active-low.
- `sram_gwen` out 1: macro global write enable, active-low.
- `sram_wen` out `DATA_W`: macro per-bit write enable, active-low.
- `sram_a` out `ADDR_W`: macro address.
- `sram_d` out `DATA_W`: macro write data.
- `sram_q` in `DATA_W`: macro read data.

## Operation
States:
- CLEAR: entered on reset when `CLEAR_ON_RESET` = 1.
  - Counter runs 0..511; one write of 0 per cycle with `wen` = all zero.
  - `req_ready` = 0 and `init_done` = 0 throughout.
  - After the write to address 511 is issued, go to RUN.
- RUN: entered on reset when `CLEAR_ON_RESET` = 0. `init_done` = 1 in this state.

Arbitration (RUN only):
- A rotating pointer `ptr` resets to 0.
- The grant goes to the first valid requester found searching from `ptr` upward, wrapping past `NUM_REQ`-1.
- `req_ready` is combinational and one-hot (or zero): high only for the granted requester.
- On an accepted request, `ptr` becomes granted index + 1, modulo `NUM_REQ`. With no request accepted, `ptr` holds.

Command mapping, registered onto the macro pins on the edge that accepts the request:
- Reads and writes: `cen` = 0, `a` = addr.
- Writes: `gwen` = 0, `wen` = ~wmask, `d` = wdata.
- Reads: `gwen` = 1, `wen` = all ones.

Idle (no accept, not CLEAR):
- `cen` = 1, `gwen` = 1, `wen` = all ones.
- `a` and `d` hold their previous values.

Read return:
- The requester index travels through a 2-stage tag pipeline.
- `rsp_valid` asserts only for reads, never for writes or clear writes.
- No response backpressure: requesters must accept data in the cycle it is presented.

Reset (any time, including mid-CLEAR or with reads in flight):
- All pipeline stages are cleared; in-flight reads produce no response.
- The clear sequence restarts from address 0.

## Timing
- Reset values: `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `sram_cen` = 1, `sram_gwen` = 1, `sram_wen` = all ones, `sram_a` = 0, `sram_d` = 0.
  - `init_done` resets to 0 when `CLEAR_ON_RESET` = 1 and to 1 when it is 0.
- Cycle t: handshake.
  - Cycle t+1: command on the macro pins; the macro samples it at the end of t+1.
  - Cycle t+2: `sram_q` valid.
  - Cycle t+3: registered `rsp_rdata` and `rsp_valid` high for exactly one cycle.
  - Read latency is 3 cycles.
- Throughput: one accepted request per cycle, so reads can have responses on consecutive cycles.
- Ordering: accesses execute in accept order. A read accepted in the cycle after a write to the same address returns the new data.
- Clear duration: the first clear write is on the pins in the cycle after reset deasserts. `init_done` rises in the cycle after the last clear write is on the pins, i.e. 513 cycles after reset release.
  - Requests may be accepted from that same cycle.

## Test plan
- **Clear after reset:** release reset with `CLEAR_ON_RESET` = 1 → 512 consecutive cycles with `sram_gwen` = 0 and `sram_a` = 0..511, `sram_d` = 0x00, `sram_wen` = 0x00; `init_done` rises after the 512th; `req_ready` stays 0 throughout.
- **Write then read:** requester 0 writes address 0x1A5, data 0x3C, mask 0xFF; then reads 0x1A5 → `rsp_valid` = 01 exactly 3 cycles after the read handshake, `rsp_rdata` = 0x3C.
- **Masked write:** address 0x010 holds 0xFF; write data 0xAB with mask 0x0F → `sram_wen` = 0xF0; a later read returns 0xFB.
- **Fairness:** both requesters hold `req_valid` high with continuous reads → grants alternate 0,1,0,1 starting from requester 0; `rsp_valid` alternates 01,10 with no idle cycles.
- **Same-address back-to-back:** requester 1 writes 0x055 with data 0x77; requester 0 reads 0x055 in the next cycle → `rsp_rdata` = 0x77.
- **Reset mid-operation:** assert `rst` with two reads in flight and during CLEAR → no `rsp_valid` pulse, all outputs at reset values, and the clear sequence restarts at address 0.
